request_latch: RTL and testbench
================================

REQUEST_LATCH -- requirements
Module: request_latch

Interface
REQ-001 Parameter: DB_COUNT, 16, consecutive stable cycles required before a debounced button level changes (legal range 1..255).
REQ-002 Port: clk  input  1  synchronizing clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: BGU  input  1  raw in-car "go upper" button, asynchronous to clk, active-high.
REQ-005 Port: BGL  input  1  raw in-car "go lower" button, asynchronous, active-high.
REQ-006 Port: BCU  input  1  raw upper-landing call button, asynchronous, active-high.
REQ-007 Port: BCL  input  1  raw lower-landing call button, asynchronous, active-high.
REQ-008 Port: OUE  input  1  open-upper-doors pulse from the elevator controller; service indication for the upper floor.
REQ-009 Port: OLE  input  1  open-lower-doors pulse from the elevator controller; service indication for the lower floor.
REQ-010 Port: GU, GL, CU, CL  output  1 each  latched requests feeding the elevator controller; registered outputs.
REQ-011 Port: PEND  output  1  registered OR of GU, GL, CU, CL.

Function
REQ-012 Each raw button SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Each synchronized button SHALL be debounced by a 4-state FSM: LOW, CHK_HI, HIGH, CHK_LO.
REQ-014 Debounce transitions:
  - LOW->CHK_HI on sync=1, with the counter loaded to 1.
  - CHK_HI->LOW on sync=0.
  - CHK_HI->HIGH when sync=1 and counter=DB_COUNT.
  - HIGH and CHK_LO behave symmetrically.
  - The counter increments while the FSM stays in a CHK state.
  - The counter is 8 bits wide and saturates, never wrapping.
REQ-015 A press event SHALL be a single-cycle pulse generated on the CHK_HI->HIGH transition only; the release transition generates no event.
REQ-016 Each request output SHALL have a 2-state FSM: IDLE (0) and REQ (1).
  - IDLE->REQ on press event.
  - REQ->IDLE on clear.
  - Clear for GU/CU is OUE=1; clear for GL/CL is OLE=1.
REQ-017 If a press event and its clear occur in the same cycle, clear SHALL win and the output SHALL go or stay 0.
REQ-018 A press event while in REQ SHALL leave the output at 1; duplicate presses produce no visible effect.
REQ-019 A button held continuously produces exactly one press event; a new request requires release (reaching LOW) and re-press.
REQ-020 Latency: a raw input rising before clk edge 0 and held stable SHALL produce a request output of 1 after clk edge DB_COUNT+3.
REQ-021 A clear SHALL drive the output to 0 on the first clk edge at which OUE/OLE is sampled high.
REQ-022 Glitches shorter than DB_COUNT synchronized cycles SHALL produce no press event.
REQ-023 PEND SHALL update one cycle after any request output changes.
REQ-024 The four button channels are independent; simultaneous presses on all four SHALL latch all four.

Reset
REQ-025 On reset=1, asynchronously:
  - synchronizer flops = 0;
  - debounce FSMs = LOW with counters = 0;
  - GU, GL, CU, CL, PEND = 0.
REQ-026 Reset asserted mid-debounce or with requests pending SHALL discard all in-progress and latched state; no press event SHALL be emitted on reset release while buttons are low.
REQ-027 A button held high through reset release SHALL register one request after DB_COUNT+3 cycles.

Structure
REQ-028 A shared package SHALL hold:
  - debounce state encodings (LOW=2'b00, CHK_HI=2'b01, HIGH=2'b10, CHK_LO=2'b11);
  - request encodings (IDLE=0, REQ=1);
  - the DB_COUNT default.
REQ-029 The synchronizer plus debounce FSM SHALL be one sub-module, button_debounce (ports clk, reset, raw, press), instantiated four times; request latches and PEND reside in request_latch.

Verification
REQ-030 Settings DB_COUNT=4; BCU high from cycle 0 -> CU=1 after edge 7, PEND=1 after edge 8; no other output changes.
REQ-031 BGL 3-cycle pulse with DB_COUNT=4 -> GL stays 0 throughout.
REQ-032 GU latched; OUE pulsed 1 cycle -> GU=0 next edge; BGU held for 100 cycles -> exactly one GU assertion.
REQ-033 Press event on CL coincides with OLE=1 -> CL=0; a later clean press -> CL=1.
REQ-034 All four buttons pressed together -> GU, GL, CU, CL all 1 on the same edge; asynchronous reset pulse mid-cycle -> all 0 immediately, with no re-latch while buttons are low.
REQ-035 Random bouncing (1-3 cycle toggles) for 50 cycles, then stable high -> exactly one request, DB_COUNT+3 cycles after stabilization.

Source files
------------

// File: rtl/request_latch_pkg.sv
// request_latch_pkg: shared encodings and defaults for the elevator request latch.
// Rev 1.0
`default_nettype none

package request_latch_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'b00,
    CHK_HI = 2'b01,
    HIGH   = 2'b10,
    CHK_LO = 2'b11
  } db_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } req_state_t;

  localparam int unsigned C_DB_COUNT_DEFAULT = 16;
  localparam int          C_CNT_W            = 8;

endpackage

`default_nettype wire

// File: rtl/request_latch_if.sv
// request_latch_if: raw buttons and service pulses in, latched requests out.
// Rev 1.0
`default_nettype none

interface request_latch_if;

  logic BGU;
  logic BGL;
  logic BCU;
  logic BCL;
  logic OUE;
  logic OLE;
  logic GU;
  logic GL;
  logic CU;
  logic CL;
  logic PEND;

  modport slave (
    input  BGU, BGL, BCU, BCL, OUE, OLE,
    output GU, GL, CU, CL, PEND
  );

  modport master (
    output BGU, BGL, BCU, BCL, OUE, OLE,
    input  GU, GL, CU, CL, PEND
  );

endinterface

`default_nettype wire

// File: rtl/request_latch_debounce.sv
// button_debounce: two-flop synchronizer plus 4-state debounce FSM; emits one
// registered pulse per accepted press. Rev 1.0
`default_nettype none

module button_debounce
  import request_latch_pkg::*;
#(
  parameter int unsigned DB_COUNT = C_DB_COUNT_DEFAULT
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  raw,
  output logic press
);

  localparam logic [C_CNT_W-1:0] C_DB_CNT = C_CNT_W'(DB_COUNT);
  localparam logic [C_CNT_W-1:0] C_ONE    = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_MAX    = {C_CNT_W{1'b1}};

  logic               r_meta;
  logic               r_sync;
  db_state_t          r_state;
  db_state_t          w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic [C_CNT_W-1:0] w_cnt_inc;
  logic               r_press;
  logic               w_press_nxt;

  assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + C_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_state <= LOW;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= raw;
      r_sync  <= r_meta;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      LOW: begin
        if (r_sync) begin
          w_state_nxt = CHK_HI;
          w_cnt_nxt   = C_ONE;
        end
      end
      CHK_HI: begin
        if (!r_sync) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_DB_CNT) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HIGH: begin
        if (!r_sync) begin
          w_state_nxt = CHK_LO;
          w_cnt_nxt   = C_ONE;
        end
      end
      CHK_LO: begin
        if (r_sync) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_DB_CNT) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/request_latch.sv
// request_latch: debounces four call/go buttons and latches them as requests
// until the matching floor is served. Rev 1.0
`default_nettype none

module request_latch
  import request_latch_pkg::*;
#(
  parameter int unsigned DB_COUNT = C_DB_COUNT_DEFAULT
) (
  input  wire            clk,
  input  wire            reset,
  request_latch_if.slave bus
);

  // Channel order: 0=GU, 1=GL, 2=CU, 3=CL
  logic [3:0] w_raw;
  logic [3:0] w_press;
  logic [3:0] w_clr;
  logic [3:0] w_req_bits;
  req_state_t r_req     [4];
  req_state_t w_req_nxt [4];
  logic       r_pend;

  assign w_raw = {bus.BCL, bus.BCU, bus.BGL, bus.BGU};
  assign w_clr = {bus.OLE, bus.OUE, bus.OLE, bus.OUE};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DB_COUNT (DB_COUNT)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (w_raw[i]),
      .press (w_press[i])
    );

    assign w_req_bits[i] = (r_req[i] == REQ);
  end

  // Clear has priority over a coincident press.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_req_nxt[i] = r_req[i];
      if (w_clr[i]) begin
        w_req_nxt[i] = IDLE;
      end else if (w_press[i]) begin
        w_req_nxt[i] = REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_req[i] <= IDLE;
      end
      r_pend <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_req[i] <= w_req_nxt[i];
      end
      r_pend <= |w_req_bits;
    end
  end

  assign bus.GU   = w_req_bits[0];
  assign bus.GL   = w_req_bits[1];
  assign bus.CU   = w_req_bits[2];
  assign bus.CL   = w_req_bits[3];
  assign bus.PEND = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_request_latch.sv
// tb_request_latch: directed self-checking bench for request_latch at DB_COUNT=4.
// Rev 1.0
`default_nettype none

module tb_request_latch;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  int   gu_rise;
  logic gu_prev;

  request_latch_if bus ();

  request_latch #(
    .DB_COUNT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {GU, GL, CU, CL, PEND}
  function automatic logic [31:0] outs();
    return {27'd0, bus.GU, bus.GL, bus.CU, bus.CL, bus.PEND};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.GU === 1'b1 && gu_prev !== 1'b1) gu_rise++;
    gu_prev = bus.GU;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int v;
    int cyc;
    int len;
    int n;

    passed  = 0;
    total   = 0;
    gu_rise = 0;
    gu_prev = 1'b0;
    reset   = 1'b1;
    bus.BGU = 1'b0;
    bus.BGL = 1'b0;
    bus.BCU = 1'b0;
    bus.BCL = 1'b0;
    bus.OUE = 1'b0;
    bus.OLE = 1'b0;

    repeat (3) tick();
    check("reset_outs", outs(), 'b00000);
    reset = 1'b0;
    tick();
    check("post_reset", outs(), 'b00000);

    // Held call-upper: CU after edge 7, PEND after edge 8
    bus.BCU = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("cu_wait", outs(), 'b00000);
    end
    tick();
    check("cu_latch", outs(), 'b00100);
    tick();
    check("cu_pend", outs(), 'b00101);
    bus.OUE = 1'b1;
    tick();
    check("cu_clear", outs(), 'b00001);
    bus.OUE = 1'b0;
    tick();
    check("pend_drop", outs(), 'b00000);
    bus.BCU = 1'b0;
    repeat (12) tick();

    // Three-cycle glitch on go-lower must be rejected
    bus.BGL = 1'b1;
    repeat (3) tick();
    bus.BGL = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("gl_glitch", outs(), 'b00000);
    end

    // Held go-upper: one assertion, cleared by OUE, no re-latch while held
    gu_rise = 0;
    bus.BGU = 1'b1;
    repeat (8) tick();
    check("gu_latch", {31'd0, bus.GU}, 1);
    bus.OUE = 1'b1;
    tick();
    check("gu_clear", {31'd0, bus.GU}, 0);
    bus.OUE = 1'b0;
    repeat (91) tick();
    check("gu_single", 32'(gu_rise), 1);
    check("gu_held_low", outs(), 'b00000);
    bus.BGU = 1'b0;
    repeat (12) tick();

    // Press event coinciding with OLE is swallowed
    bus.BCL = 1'b1;
    repeat (7) tick();
    bus.OLE = 1'b1;
    tick();
    check("cl_coincide", outs(), 'b00000);
    bus.OLE = 1'b0;
    tick();
    check("cl_stay0", outs(), 'b00000);
    bus.BCL = 1'b0;
    repeat (12) tick();
    bus.BCL = 1'b1;
    repeat (8) tick();
    check("cl_relatch", outs(), 'b00010);
    bus.OLE = 1'b1;
    tick();
    bus.OLE = 1'b0;
    bus.BCL = 1'b0;
    repeat (12) tick();
    check("idle_before_all", outs(), 'b00000);

    // All four together, then asynchronous reset mid-cycle
    bus.BGU = 1'b1;
    bus.BGL = 1'b1;
    bus.BCU = 1'b1;
    bus.BCL = 1'b1;
    repeat (7) tick();
    check("all_wait", outs(), 'b00000);
    tick();
    check("all_latch", outs(), 'b11110);
    tick();
    check("all_pend", outs(), 'b11111);
    bus.BGU = 1'b0;
    bus.BGL = 1'b0;
    bus.BCU = 1'b0;
    bus.BCL = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", outs(), 'b00000);
    #2;
    reset = 1'b0;
    repeat (15) tick();
    check("no_relatch", outs(), 'b00000);

    // Bounce with 1..3-cycle runs, then stable high
    gu_rise = 0;
    v   = 1;
    cyc = 0;
    while (cyc < 50) begin
      len     = int'($urandom_range(1, 3));
      bus.BGU = v[0];
      repeat (len) tick();
      cyc += len;
      v = 1 - v;
    end
    bus.BGU = 1'b0;
    repeat (3) tick();
    check("bounce_quiet", 32'(gu_rise), 0);
    bus.BGU = 1'b1;
    n = 0;
    while (n < 30 && bus.GU !== 1'b1) begin
      tick();
      n++;
    end
    check("bounce_latency", 32'(n), 8);
    repeat (30) tick();
    check("bounce_single", 32'(gu_rise), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
